// File: rtl/led_matrix_pkg.sv
// Shared types and timing helpers for the RGB LED matrix scan driver.
// The bench uses the same helpers to derive its expected frame timing.
package led_matrix_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHOW,
    BLANK
  } state_t;

  localparam int PIX_BPC = 4;

  typedef struct packed {
    logic [PIX_BPC-1:0] r;
    logic [PIX_BPC-1:0] g;
    logic [PIX_BPC-1:0] b;
  } pixel_t;

  function automatic int steps_f(input int bpc);
    return (1 << bpc) - 1;
  endfunction

  function automatic int row_period_f(
    input int cols,
    input int bpc,
    input int row_cycles,
    input int blank_cycles
  );
    return cols + 1 + steps_f(bpc) * row_cycles + blank_cycles;
  endfunction

endpackage

// File: rtl/led_frame_buf.sv
// Dual-bank pixel store: one write port, one registered read port.
// The address MSB selects the bank.
module led_frame_buf #(
  parameter int AW = 8,
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW:0]   wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW:0]   rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [2**(AW+1)];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/led_matrix_scan.sv
// Row-scanning PWM driver for an RGB LED matrix with tear-free bank swap.
// Outputs are registered from next-state values, so they change on clock edges only.
module led_matrix_scan #(
  parameter  int ROWS         = 16,
  parameter  int COLS         = 16,
  parameter  int BPC          = 4,
  parameter  int ROW_CYCLES   = 64,
  parameter  int BLANK_CYCLES = 8,
  localparam int AW           = $clog2(ROWS * COLS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [3*BPC-1:0] wr_data,
  input  logic             swap_req,
  output logic             swap_ack,
  output logic             frame_tick,
  output logic             active,
  output logic [ROWS-1:0]  row_sel,
  output logic [COLS-1:0]  col_r,
  output logic [COLS-1:0]  col_g,
  output logic [COLS-1:0]  col_b
);
  import led_matrix_pkg::*;

  localparam int NPIX  = ROWS * COLS;
  localparam int STEPS = steps_f(BPC);
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int M1    = (COLS > ROW_CYCLES) ? COLS : ROW_CYCLES;
  localparam int CMAX  = (M1 > BLANK_CYCLES) ? M1 : BLANK_CYCLES;
  localparam int CW    = $clog2(CMAX + 1);

  localparam logic [CW-1:0]  LOAD_END  = CW'(COLS);
  localparam logic [CW-1:0]  STEP_END  = CW'(ROW_CYCLES - 1);
  localparam logic [CW-1:0]  BLANK_END = CW'(BLANK_CYCLES - 1);
  localparam logic [BPC-1:0] PWM_END   = BPC'(STEPS - 1);
  localparam logic [RW-1:0]  ROW_END   = RW'(ROWS - 1);

  typedef struct packed {
    logic [BPC-1:0] r;
    logic [BPC-1:0] g;
    logic [BPC-1:0] b;
  } pix_t;

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [BPC-1:0] pwm, pwm_n;
  logic [RW-1:0]  row, row_n;
  logic           front, front_n;
  logic           swap_pending, pend_n;
  logic           ack_n, tick_n, active_n;
  logic           swap_pt;
  logic           show_n;

  logic           wr_ok;
  logic [AW-1:0]  pix_addr;
  logic [3*BPC-1:0] rd_data;
  pix_t           rd_pix;
  logic           lat_we;
  logic [CW-1:0]  lat_col;
  logic [COLS-1:0] col_r_n, col_g_n, col_b_n;

  assign wr_ok    = {1'b0, wr_addr} < (AW+1)'(NPIX);
  assign pix_addr = AW'(row) * AW'(COLS) + AW'(cnt);
  assign rd_pix   = pix_t'(rd_data);
  assign lat_we   = (state == LOAD) && (cnt != '0);
  assign lat_col  = cnt - 1'b1;

  led_frame_buf #(
    .AW (AW),
    .DW (3 * BPC)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en && wr_ok),
    .wr_addr ({~front, wr_addr}),
    .wr_data (wr_data),
    .rd_addr ({front, pix_addr}),
    .rd_data (rd_data)
  );

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    pwm_n    = pwm;
    row_n    = row;
    front_n  = front;
    pend_n   = swap_pending | swap_req;
    ack_n    = 1'b0;
    tick_n   = 1'b0;
    active_n = active;
    swap_pt  = 1'b0;
    unique case (state)
      IDLE: swap_pt = 1'b1;
      LOAD: begin
        if (cnt == LOAD_END) begin
          state_n = SHOW;
          cnt_n   = '0;
          pwm_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      SHOW: begin
        if (cnt == STEP_END) begin
          cnt_n = '0;
          if (pwm == PWM_END) state_n = BLANK;
          else pwm_n = pwm + 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      BLANK: begin
        if (cnt == BLANK_END) begin
          cnt_n   = '0;
          state_n = LOAD;
          if (row == ROW_END) begin
            row_n   = '0;
            tick_n  = 1'b1;
            swap_pt = 1'b1;
          end else begin
            row_n = row + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // Swap only at a frame boundary; stacked requests merge into one.
    if (swap_pt && pend_n) begin
      front_n  = ~front;
      ack_n    = 1'b1;
      pend_n   = 1'b0;
      active_n = 1'b1;
      if (state == IDLE) begin
        state_n = LOAD;
        cnt_n   = '0;
        row_n   = '0;
      end
    end
  end

  assign show_n = (state_n == SHOW);

  // Per-column row latch; the column arriving this cycle bypasses the latch.
  for (genvar c = 0; c < COLS; c++) begin : g_col
    logic [BPC-1:0] lr, lg, lb;
    logic           hit;
    pix_t           eff;
    assign hit = lat_we && (lat_col == CW'(c));
    always_ff @(posedge clk) begin
      if (hit) begin
        lr <= rd_pix.r;
        lg <= rd_pix.g;
        lb <= rd_pix.b;
      end
    end
    assign eff        = hit ? rd_pix : pix_t'({lr, lg, lb});
    assign col_r_n[c] = show_n && (eff.r > pwm_n);
    assign col_g_n[c] = show_n && (eff.g > pwm_n);
    assign col_b_n[c] = show_n && (eff.b > pwm_n);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      pwm          <= '0;
      row          <= '0;
      front        <= 1'b0;
      swap_pending <= 1'b0;
      swap_ack     <= 1'b0;
      frame_tick   <= 1'b0;
      active       <= 1'b0;
      row_sel      <= '1;
      col_r        <= '0;
      col_g        <= '0;
      col_b        <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      pwm          <= pwm_n;
      row          <= row_n;
      front        <= front_n;
      swap_pending <= pend_n;
      swap_ack     <= ack_n;
      frame_tick   <= tick_n;
      active       <= active_n;
      row_sel      <= show_n ? ~(ROWS'(1) << row_n) : '1;
      col_r        <= col_r_n;
      col_g        <= col_g_n;
      col_b        <= col_b_n;
    end
  end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Directed bench for led_matrix_scan: frame table driven through a
// pixel model, plus reset, idle, and mid-frame commit sequences.
module tb_led_matrix_scan;
  import led_matrix_pkg::*;

  localparam int ROWS  = 16;
  localparam int COLS  = 16;
  localparam int BPC   = 4;
  localparam int RC    = 64;
  localparam int BC    = 8;
  localparam int STEPS = 15;
  localparam int SHOWN = STEPS * RC;
  localparam int ROW_P = row_period_f(COLS, BPC, RC, BC);
  localparam int NPIX  = ROWS * COLS;

  logic            clk = 1'b0;
  logic            rst;
  logic            wr_en;
  logic [7:0]      wr_addr;
  logic [11:0]     wr_data;
  logic            swap_req;
  logic            swap_ack;
  logic            frame_tick;
  logic            active;
  logic [ROWS-1:0] row_sel;
  logic [COLS-1:0] col_r, col_g, col_b;

  led_matrix_scan #(
    .ROWS         (ROWS),
    .COLS         (COLS),
    .BPC          (BPC),
    .ROW_CYCLES   (RC),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .swap_req   (swap_req),
    .swap_ack   (swap_ack),
    .frame_tick (frame_tick),
    .active     (active),
    .row_sel    (row_sel),
    .col_r      (col_r),
    .col_g      (col_g),
    .col_b      (col_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [11:0] fill;
    int          sp;
    logic [11:0] spv;
    bit          swp;
    int          prow;
    int          pch;
    int          pcol;
    int          pon;
  } frm_t;

  frm_t   tbl [4];
  pixel_t front_m [NPIX];
  pixel_t back_m  [NPIX];
  bit     pend = 1'b0;
  int     checks = 0;
  int     errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic swap_model();
    pixel_t t;
    for (int a = 0; a < NPIX; a++) begin
      t          = front_m[a];
      front_m[a] = back_m[a];
      back_m[a]  = t;
    end
  endtask

  task automatic fill(logic [11:0] v, int sp, logic [11:0] spv);
    for (int a = 0; a < NPIX; a++) begin
      @(negedge clk);
      wr_en     = 1'b1;
      wr_addr   = 8'(a);
      wr_data   = (a == sp) ? spv : v;
      back_m[a] = wr_data;
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic garbage(int n);
    int a;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      a         = $urandom_range(0, NPIX - 1);
      wr_en     = 1'b1;
      wr_addr   = 8'(a);
      wr_data   = 12'($urandom);
      back_m[a] = wr_data;
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_swap(output int t);
    @(negedge clk);
    swap_req = 1'b1;
    t        = cyc;
    @(negedge clk);
    swap_req = 1'b0;
  endtask

  task automatic wait_row(string tag, int r, int lim);
    logic [ROWS-1:0] es;
    int n;
    es    = '1;
    es[r] = 1'b0;
    n     = 0;
    while (row_sel !== es && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " wait"}, row_sel, es);
  endtask

  task automatic show_row(string tag, int r, int s, int fi);
    logic [ROWS-1:0] es;
    logic [COLS-1:0] er, eg, eb, pb;
    pixel_t p;
    int n, bsel, bcol, bctl, on;
    es    = '1;
    es[r] = 1'b0;
    n     = 0;
    while (row_sel !== es && n < 2 * ROW_P) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " start"}, cyc, s);
    bsel = 0; bcol = 0; bctl = 0; on = 0;
    for (int k = 0; k < SHOWN; k++) begin
      for (int c = 0; c < COLS; c++) begin
        p     = front_m[r * COLS + c];
        er[c] = int'(p.r) > k / RC;
        eg[c] = int'(p.g) > k / RC;
        eb[c] = int'(p.b) > k / RC;
      end
      if (row_sel !== es) bsel++;
      if ({col_r, col_g, col_b} !== {er, eg, eb}) bcol++;
      if (swap_ack || frame_tick) bctl++;
      pb = (tbl[fi].pch == 0) ? col_r : (tbl[fi].pch == 1) ? col_g : col_b;
      if (pb[tbl[fi].pcol]) on++;
      @(negedge clk);
    end
    chk({tag, " sel"}, bsel, 0);
    chk({tag, " cols"}, bcol, 0);
    chk({tag, " ctl"}, bctl, 0);
    if (r == tbl[fi].prow) chk({tag, " probe"}, on, tbl[fi].pon);
    chk({tag, " dark"}, {row_sel, col_r | col_g | col_b}, {16'hFFFF, 16'h0});
  endtask

  task automatic show_frame(int fi, int s0);
    int pre;
    for (int r = 0; r < ROWS; r++)
      show_row($sformatf("%s r%0d", tbl[fi].name, r), r, s0 + r * ROW_P, fi);
    pre = 0;
    repeat (BC) begin
      if (frame_tick || swap_ack) pre++;
      @(negedge clk);
    end
    chk({tbl[fi].name, " early"}, pre, 0);
    chk({tbl[fi].name, " tick"}, frame_tick, 1);
    chk({tbl[fi].name, " ack"}, swap_ack, pend);
    if (swap_ack && pend) swap_model();
    pend = 1'b0;
  endtask

  task automatic prep(int i);
    int t;
    if (i + 1 < 4) begin
      wait_row($sformatf("prep%0d", i), 3, 4 * ROW_P);
      if (tbl[i + 1].swp) begin
        fill(tbl[i + 1].fill, tbl[i + 1].sp, tbl[i + 1].spv);
        pulse_swap(t);
        pend = 1'b1;
      end else begin
        garbage(300);
      end
    end
  endtask

  initial begin
    int t, s0, bad;
    tbl[0] = '{"red",  12'hF00, -1, 12'h000, 1'b1,  0, 0,  0, 960};
    tbl[1] = '{"pwm",  12'h000, 37, 12'h050, 1'b1,  2, 1,  5, 320};
    tbl[2] = '{"blue", 12'h009, -1, 12'h000, 1'b1, 15, 2, 15, 576};
    tbl[3] = '{"hold", 12'h000, -1, 12'h000, 1'b0,  7, 2,  3, 576};

    rst      = 1'b1;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    swap_req = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst row_sel", row_sel, 16'hFFFF);
    chk("rst cols", {col_r, col_g, col_b}, 48'h0);
    chk("rst flags", {swap_ack, frame_tick, active}, 3'b000);
    rst = 1'b0;

    bad = 0;
    repeat (20000) begin
      @(negedge clk);
      if (row_sel !== 16'hFFFF || (col_r | col_g | col_b) !== 16'h0) bad++;
      if (swap_ack || frame_tick || active) bad++;
    end
    chk("idle dark", bad, 0);

    fill(tbl[0].fill, tbl[0].sp, tbl[0].spv);
    @(negedge clk);
    swap_req = 1'b1;
    t        = cyc;
    chk("ack before", swap_ack, 0);
    @(negedge clk);
    swap_req = 1'b0;
    chk("ack t+1 cyc", cyc, t + 1);
    chk("ack t+1", swap_ack, 1);
    chk("active", active, 1);
    swap_model();
    s0 = t + COLS + 2;

    for (int i = 0; i < 4; i++) begin
      fork
        show_frame(i, s0);
        prep(i);
      join
      s0 += ROWS * ROW_P;
    end

    wait_row("final", 0, 2 * ROW_P);
    chk("frame5 start", cyc, s0);
    repeat (100) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async row_sel", row_sel, 16'hFFFF);
    chk("async cols", {col_r, col_g, col_b}, 48'h0);
    chk("async active", active, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (row_sel !== 16'hFFFF || active || frame_tick || swap_ack) bad++;
    end
    chk("post rst idle", bad, 0);
    pulse_swap(t);
    chk("post rst ack", swap_ack, 1);
    chk("post rst active", active, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
